// File: rtl/bnn_inference_sequencer.sv
// Inference sequencer for the BNN core: accepts one image per handshake,
// latches it for the core, drives the core clock-enable and start strobe,
// watches for completion with a watchdog and holds the result until acked.
module bnn_inference_sequencer #(
  parameter int IMG_BITS   = 900,
  parameter int CLK_DIV    = 4,
  parameter int TIMEOUT    = 4096,
  parameter int BLANK_CODE = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                img_valid,
  output logic                img_ready,
  input  logic [IMG_BITS-1:0] img_data,
  input  logic                abort,
  output logic [IMG_BITS-1:0] core_img,
  output logic                core_clk_en,
  output logic                core_start,
  input  logic                core_done,
  input  logic [3:0]          core_result,
  output logic                res_valid,
  output logic [3:0]          res_data,
  output logic                res_err,
  input  logic                res_ack,
  output logic                busy,
  output logic [15:0]         infer_count
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_RUN    = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int WD_W  = $clog2(TIMEOUT + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);

  logic [1:0]       state;
  logic [1:0]       state_nx;
  logic [DIV_W-1:0] div;
  logic [WD_W-1:0]  wd;
  logic             in_core;
  logic             next_in_core;
  logic             accept;
  logic             blank;
  logic             run_done;
  logic             run_tmo;
  logic             hold_entry;

  // Saturating result counter increment.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Decode status outputs and the events that drive the state machine.
  always_comb begin
    in_core      = (state == S_LAUNCH) || (state == S_RUN);
    core_clk_en  = in_core && (div == '0);
    core_start   = (state == S_LAUNCH);
    img_ready    = (state == S_IDLE);
    busy         = (state != S_IDLE);
    res_valid    = (state == S_HOLD);
    accept       = img_ready && img_valid && !abort;
    blank        = (img_data == '0);
    run_done     = (state == S_RUN) && core_clk_en && core_done;
    run_tmo      = (state == S_RUN) && core_clk_en && !core_done && (wd == WD_LAST);
    hold_entry   = !abort && ((accept && blank) || run_done || run_tmo);
  end

  // Next-state logic; abort overrides every transition.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (accept) state_nx = blank ? S_HOLD : S_LAUNCH;
      S_LAUNCH: if (core_clk_en) state_nx = S_RUN;
      S_RUN:    if (run_done || run_tmo) state_nx = S_HOLD;
      S_HOLD:   if (res_ack) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
    if (abort) state_nx = S_IDLE;
    next_in_core = (state_nx == S_LAUNCH) || (state_nx == S_RUN);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Clock-enable divider: free-runs only while staying inside LAUNCH/RUN,
  // so it enters LAUNCH at zero and the first enable lands on that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        div <= '0;
    else if (!(in_core && next_in_core)) div <= '0;
    else if (div == DIV_LAST)          div <= '0;
    else                               div <= div + DIV_W'(1);
  end

  // Watchdog counts enable pulses in RUN that arrive without core_done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                      wd <= '0;
    else if (abort)                                  wd <= '0;
    else if ((state == S_LAUNCH) && core_clk_en)     wd <= '0;
    else if ((state == S_RUN) && core_clk_en && !core_done && (wd != WD_LAST))
                                                     wd <= wd + WD_W'(1);
  end

  // Image register only changes on an accepted handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      core_img <= '0;
    else if (accept) core_img <= img_data;
  end

  // Result hold register; abort only clears the error flag, the code stays.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_data <= 4'h0;
      res_err  <= 1'b0;
    end else if (abort) begin
      res_err  <= 1'b0;
    end else if (accept && blank) begin
      res_data <= 4'(BLANK_CODE);
      res_err  <= 1'b0;
    end else if (run_done) begin
      res_data <= core_result;
      res_err  <= 1'b0;
    end else if (run_tmo) begin
      res_data <= 4'hF;
      res_err  <= 1'b1;
    end
  end

  // Count every result that actually reaches HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          infer_count <= 16'h0000;
    else if (hold_entry) infer_count <= sat_inc(infer_count);
  end

endmodule

// File: tb/tb_bnn_inference_sequencer.sv
// Self-checking bench for bnn_inference_sequencer: table vectors, random
// transactions against a latency/result model, and hand-written corner cases.
module tb_bnn_inference_sequencer;

  localparam int IMG_BITS = 900;
  localparam int CLK_DIV  = 4;
  localparam int TIMEOUT  = 8;
  localparam int BLANK    = 10;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                img_valid = 1'b0;
  logic                img_ready;
  logic [IMG_BITS-1:0] img_data = '0;
  logic                abort = 1'b0;
  logic [IMG_BITS-1:0] core_img;
  logic                core_clk_en;
  logic                core_start;
  logic                core_done = 1'b0;
  logic [3:0]          core_result = 4'h0;
  logic                res_valid;
  logic [3:0]          res_data;
  logic                res_err;
  logic                res_ack = 1'b0;
  logic                busy;
  logic [15:0]         infer_count;

  int checks = 0;
  int errors = 0;
  logic [15:0] model_count = 16'h0;

  bnn_inference_sequencer #(
    .IMG_BITS(IMG_BITS), .CLK_DIV(CLK_DIV), .TIMEOUT(TIMEOUT), .BLANK_CODE(BLANK)
  ) dut (
    .clk(clk), .rst_n(rst_n), .img_valid(img_valid), .img_ready(img_ready),
    .img_data(img_data), .abort(abort), .core_img(core_img),
    .core_clk_en(core_clk_en), .core_start(core_start), .core_done(core_done),
    .core_result(core_result), .res_valid(res_valid), .res_data(res_data),
    .res_err(res_err), .res_ack(res_ack), .busy(busy), .infer_count(infer_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         blank;
    int         k;
    logic [3:0] res;
    int         exp_cyc;
    logic [3:0] exp_data;
    logic       exp_err;
    int         ack_wait;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [IMG_BITS-1:0] rand_img();
    logic [IMG_BITS-1:0] v;
    for (int i = 0; i < IMG_BITS; i++) v[i] = ($urandom_range(0, 3) == 0);
    v[$urandom_range(0, IMG_BITS-1)] = 1'b1;
    return v;
  endfunction

  // Reference: blank images finish one cycle after acceptance; otherwise the
  // k-th RUN enable pulse (counted from 1) ends the run, unless the watchdog
  // sees TIMEOUT unanswered pulses first.
  task automatic model(input bit blank, input int k, input logic [3:0] r,
                       output int cyc, output logic [3:0] d, output logic e);
    if (blank) begin
      cyc = 1; d = 4'(BLANK); e = 1'b0;
    end else if (k >= 1 && k <= TIMEOUT) begin
      cyc = 2 + k * CLK_DIV; d = r; e = 1'b0;
    end else begin
      cyc = 2 + TIMEOUT * CLK_DIV; d = 4'hF; e = 1'b1;
    end
  endtask

  // Offer one image, play the core (done on the k-th RUN pulse, k=0 never),
  // check the result, then ack after ack_wait cycles (negative: leave in HOLD).
  task automatic run_one(input string tag, input logic [IMG_BITS-1:0] img, input int k,
                         input logic [3:0] res, input int exp_cyc, input logic [3:0] exp_data,
                         input logic exp_err, input int ack_wait);
    int n, cyc, starts, pulses, exp_starts, exp_pulses;
    bit got, img_ok, stable;
    @(negedge clk);
    check({tag, " ready"}, img_ready, 1);
    img_valid = 1'b1;
    img_data  = img;
    @(negedge clk);
    img_valid = 1'b0;
    img_data  = ~img;
    n = 0; cyc = 1; starts = 0; pulses = 0; got = 0; img_ok = 1;
    while (!got && cyc <= 200) begin
      if (core_start) starts++;
      if (core_clk_en) pulses++;
      if (core_img !== img) img_ok = 0;
      if (res_valid) begin
        got = 1;
        core_done = 1'b0;
        res_ack = (ack_wait == 0);
      end else begin
        core_done   = 1'b0;
        core_result = 4'($urandom);
        res_ack     = 1'($urandom_range(0, 1));
        if (core_clk_en && !core_start) begin
          n++;
          core_done = (n == k);
          core_result = res;
        end else if (!core_start) begin
          core_done = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        cyc++;
      end
    end
    exp_starts = (img == '0) ? 0 : 1;
    exp_pulses = (img == '0) ? 0 : 1 + (exp_cyc - 2) / CLK_DIV;
    model_count = (model_count == 16'hFFFF) ? model_count : model_count + 16'd1;
    check({tag, " result seen"}, got, 1);
    check({tag, " latency"}, cyc, exp_cyc);
    check({tag, " res_data"}, res_data, exp_data);
    check({tag, " res_err"}, res_err, exp_err);
    check({tag, " start cycles"}, starts, exp_starts);
    check({tag, " enable pulses"}, pulses, exp_pulses);
    check({tag, " core_img"}, img_ok, 1);
    check({tag, " count"}, infer_count, model_count);
    if (!got) begin
      abort = 1'b1; @(negedge clk); abort = 1'b0;
    end else if (ack_wait >= 0) begin
      stable = 1;
      for (int i = 0; i < ack_wait; i++) begin
        core_done = 1'($urandom_range(0, 1));
        @(negedge clk);
        if (!res_valid || res_data !== exp_data || res_err !== exp_err || img_ready) stable = 0;
      end
      core_done = 1'b0;
      res_ack = 1'b1;
      @(negedge clk);
      res_ack = 1'b0;
      check({tag, " hold stable"}, stable, 1);
      check({tag, " valid after ack"}, res_valid, 0);
      check({tag, " ready after ack"}, img_ready, 1);
      check({tag, " data kept"}, res_data, exp_data);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " img_ready"}, img_ready, 1);
    check({tag, " busy"}, busy, 0);
    check({tag, " core_start"}, core_start, 0);
    check({tag, " core_clk_en"}, core_clk_en, 0);
    check({tag, " res_valid"}, res_valid, 0);
    check({tag, " res_err"}, res_err, 0);
    check({tag, " res_data"}, res_data, 0);
    check({tag, " count"}, infer_count, 0);
    check({tag, " core_img zero"}, (core_img == '0), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL global time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [IMG_BITS-1:0] img, img_b;
    int cyc;
    logic [3:0] d, r;
    logic e;
    bit bl;
    int k;

    tbl[0] = '{1'b0, 2, 4'd7, 10, 4'd7, 1'b0, 2};
    tbl[1] = '{1'b1, 0, 4'd0, 1, 4'd10, 1'b0, 1};
    tbl[2] = '{1'b0, 0, 4'd0, 34, 4'hF, 1'b1, 0};
    tbl[3] = '{1'b0, 1, 4'd3, 6, 4'd3, 1'b0, 0};
    tbl[4] = '{1'b0, 8, 4'd5, 34, 4'd5, 1'b0, 1};
    tbl[5] = '{1'b0, 9, 4'd6, 34, 4'hF, 1'b1, 3};

    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Table vectors; the first one uses an image with only bit 5 set.
    for (int i = 0; i < 6; i++) begin
      if (tbl[i].blank) img = '0;
      else if (i == 0) begin img = '0; img[5] = 1'b1; end
      else img = rand_img();
      run_one($sformatf("vec%0d", i), img, tbl[i].k, tbl[i].res,
              tbl[i].exp_cyc, tbl[i].exp_data, tbl[i].exp_err, tbl[i].ack_wait);
    end

    // Back-to-back random transactions against the model.
    for (int i = 0; i < 20; i++) begin
      bl = ($urandom_range(0, 4) == 0);
      k  = $urandom_range(0, TIMEOUT + 2);
      r  = 4'($urandom);
      img = bl ? '0 : rand_img();
      model(bl, k, r, cyc, d, e);
      run_one($sformatf("rnd%0d", i), img, k, r, cyc, d, e, $urandom_range(0, 3));
    end

    // A second image held during HOLD is only taken after the ack.
    img_b = rand_img();
    @(negedge clk);
    img_valid = 1'b1; img_data = '0;
    @(negedge clk);
    img_data = img_b;
    model_count = model_count + 16'd1;
    check("held blank res_data", res_data, BLANK);
    repeat (3) @(negedge clk);
    check("held img_ready", img_ready, 0);
    check("held core_img", (core_img == '0), 1);
    check("held count", infer_count, model_count);
    res_ack = 1'b1;
    @(negedge clk);
    res_ack = 1'b0;
    check("held idle ready", img_ready, 1);
    @(negedge clk);
    img_valid = 1'b0;
    check("held accepted start", core_start, 1);
    check("held accepted img", (core_img == img_b), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort launch busy", busy, 0);
    check("abort launch start", core_start, 0);
    check("abort launch count", infer_count, model_count);

    // Abort in RUN on the very pulse that carries done: result discarded.
    img = rand_img();
    img_valid = 1'b1; img_data = img;
    @(negedge clk);
    img_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("abort run pulse", core_clk_en, 1);
    core_done = 1'b1; core_result = 4'd2; abort = 1'b1;
    @(negedge clk);
    core_done = 1'b0; abort = 1'b0;
    check("abort run busy", busy, 0);
    check("abort run valid", res_valid, 0);
    check("abort run count", infer_count, model_count);
    check("abort run core_img", (core_img == img), 1);
    repeat (6) @(negedge clk);
    check("abort run stays idle", busy, 0);

    // Timeout result left in HOLD, then abort together with ack.
    run_one("tmo hold", rand_img(), 0, 4'd0, 34, 4'hF, 1'b1, -1);
    abort = 1'b1; res_ack = 1'b1;
    @(negedge clk);
    abort = 1'b0; res_ack = 1'b0;
    check("abort hold valid", res_valid, 0);
    check("abort hold err", res_err, 0);
    check("abort hold ready", img_ready, 1);
    check("abort hold count", infer_count, model_count);

    // Abort together with img_valid in IDLE: not accepted.
    img = core_img;
    img_valid = 1'b1; img_data = rand_img(); abort = 1'b1;
    @(negedge clk);
    img_valid = 1'b0; abort = 1'b0;
    check("abort idle busy", busy, 0);
    check("abort idle core_img", (core_img == img), 1);

    // Saturation of the result counter from a preloaded value.
    force dut.infer_count = 16'hFFFD;
    #1;
    release dut.infer_count;
    model_count = 16'hFFFD;
    check("preload count", infer_count, 16'hFFFD);
    run_one("sat1", '0, 0, 4'd0, 1, 4'(BLANK), 1'b0, 0);
    run_one("sat2", '0, 0, 4'd0, 1, 4'(BLANK), 1'b0, 0);
    check("sat reached", infer_count, 16'hFFFF);
    run_one("sat3", rand_img(), 1, 4'd9, 6, 4'd9, 1'b0, 0);
    check("sat held", infer_count, 16'hFFFF);

    // Asynchronous reset in LAUNCH.
    img_valid = 1'b1; img_data = rand_img();
    @(negedge clk);
    img_valid = 1'b0;
    check("pre-reset launch", core_start, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("async reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post reset idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
